// File: rtl/maple_port_sched_pkg.sv
// Shared definitions for the Maple port sequencer: port geometry, FSM state encodings
// and a small index-to-one-hot helper.
package maple_port_sched_pkg;

    localparam int NPORTS = 4;
    localparam int PORT_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_TX      = 3'd2,
        ST_TURN    = 3'd3,
        ST_RX      = 3'd4,
        ST_RELEASE = 3'd5
    } state_e;

    function automatic logic [NPORTS-1:0] port_onehot(input logic [PORT_W-1:0] idx);
        return NPORTS'(1) << idx;
    endfunction

endpackage

// File: rtl/maple_port_sched_rr_arb4.sv
// Combinational round-robin pick: first requesting port searching upward from last+1,
// wrapping so that the previous owner is considered last.
module rr_arb4
    import maple_port_sched_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic [PORT_W-1:0] last,
    output logic              valid,
    output logic [PORT_W-1:0] idx
);

    logic [PORT_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NPORTS; k >= 1; k--) begin
            cand = last + PORT_W'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/maple_port_sched.sv
// Maple bus port sequencer: round-robin grant, then settle -> transmit -> turnaround ->
// receive window -> release for the granted port. All outputs are registered.
module maple_port_sched
    import maple_port_sched_pkg::*;
#(
    parameter int TURNAROUND = 4,
    parameter int RX_TIMEOUT = 48000,
    parameter int TO_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NPORTS-1:0] req,
    input  logic              abort,
    input  logic              tx_done,
    input  logic              rx_frame_end,
    output logic [NPORTS-1:0] grant,
    output logic [PORT_W-1:0] port_select,
    output logic              oe,
    output logic              tx_start,
    output logic              rx_enable,
    output logic              done,
    output logic              timeout,
    output logic [2:0]        state_dbg
);

    localparam logic [TO_W-1:0] TURN_LAST = TO_W'(TURNAROUND - 1);
    localparam logic [TO_W-1:0] RX_LAST   = TO_W'(RX_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [PORT_W-1:0] last_port_q, last_port_d;
    logic [NPORTS-1:0] grant_q, grant_d;
    logic [PORT_W-1:0] port_select_q, port_select_d;
    logic              oe_q, oe_d;
    logic              tx_start_q, tx_start_d;
    logic              rx_enable_q, rx_enable_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic              arb_valid;
    logic [PORT_W-1:0] arb_idx;

    rr_arb4 u_arb (
        .req   (req),
        .last  (last_port_q),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_port_d   = last_port_q;
        grant_d       = grant_q;
        port_select_d = port_select_q;
        oe_d          = 1'b0;
        tx_start_d    = 1'b0;
        rx_enable_d   = 1'b0;
        done_d        = 1'b0;
        timeout_d     = 1'b0;

        // Abort outranks tx_done and rx_frame_end in every active state.
        if (abort && (state_q inside {ST_GRANT, ST_TX, ST_TURN, ST_RX})) begin
            state_d   = ST_RELEASE;
            grant_d   = '0;
            timeout_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        state_d       = ST_GRANT;
                        grant_d       = port_onehot(arb_idx);
                        port_select_d = arb_idx;
                    end
                end
                ST_GRANT: begin
                    state_d    = ST_TX;
                    tx_start_d = 1'b1;
                    oe_d       = 1'b1;
                end
                ST_TX: begin
                    if (tx_done) begin
                        state_d = ST_TURN;
                        cnt_d   = '0;
                    end else begin
                        oe_d = 1'b1;
                    end
                end
                ST_TURN: begin
                    if (cnt_q == TURN_LAST) begin
                        state_d     = ST_RX;
                        cnt_d       = '0;
                        rx_enable_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + TO_W'(1);
                    end
                end
                ST_RX: begin
                    if (rx_frame_end) begin
                        state_d = ST_RELEASE;
                        grant_d = '0;
                        done_d  = 1'b1;
                    end else if (cnt_q == RX_LAST) begin
                        state_d   = ST_RELEASE;
                        grant_d   = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d       = cnt_q + TO_W'(1);
                        rx_enable_d = 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state_d     = ST_IDLE;
                    last_port_d = port_select_q;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            last_port_q   <= PORT_W'(NPORTS - 1);
            grant_q       <= '0;
            port_select_q <= '0;
            oe_q          <= 1'b0;
            tx_start_q    <= 1'b0;
            rx_enable_q   <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_port_q   <= last_port_d;
            grant_q       <= grant_d;
            port_select_q <= port_select_d;
            oe_q          <= oe_d;
            tx_start_q    <= tx_start_d;
            rx_enable_q   <= rx_enable_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign port_select = port_select_q;
    assign oe          = oe_q;
    assign tx_start    = tx_start_q;
    assign rx_enable   = rx_enable_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign state_dbg   = state_q;

endmodule
